// File: rtl/sopc_bus_pkg.sv
// Shared encodings for the SOPC memory-bus arbiter and its wait-state counter.
// The peripheral bridge uses the same encodings.
package sopc_bus_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t DONE   = 2'd2;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    localparam logic [3:0] SEL_WORD = 4'hF;

    // Holds MEM_LAT-1 for MEM_LAT up to 7.
    localparam int WAIT_W = 3;

endpackage

// File: rtl/sopc_bus_waitcnt.sv
// Loadable down-counter that flags the final wait-state cycle of a bus access.
// The arbiter loads MEM_LAT-1, so last_o rises after MEM_LAT-1 enabled cycles.
module sopc_bus_waitcnt
    import sopc_bus_pkg::*;
#(
    parameter int W = WAIT_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/sopc_bus_arbiter.sv
// Shares the single-port instruction/data memory between the fetch and load/store ports.
// Each access costs MEM_LAT wait states plus one ack cycle and one idle cycle.
module sopc_bus_arbiter
    import sopc_bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              stall_if_o,
    output logic              stall_mem_o
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    state_t              state_q,     state_d;
    logic                gnt_q,       gnt_d;
    logic                bus_ce_q,    bus_ce_d;
    logic                bus_we_q,    bus_we_d;
    logic [3:0]          bus_sel_q,   bus_sel_d;
    logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_ack_q,    if_ack_d;
    logic                mem_ack_q,   mem_ack_d;
    logic [STARVE_W-1:0] starve_q,    starve_d;

    logic wc_load;
    logic wc_en;
    logic wc_last;
    logic if_starved;

    sopc_bus_waitcnt #(
        .W (WAIT_W)
    ) u_waitcnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (wc_load),
        .load_val_i (WAIT_W'(MEM_LAT - 1)),
        .en_i       (wc_en),
        .last_o     (wc_last)
    );

    assign if_starved = if_req_i && (starve_q == STARVE_W'(STARVE_MAX));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        bus_ce_d    = bus_ce_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        starve_d    = starve_q;
        wc_load     = 1'b0;
        wc_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req_i || mem_req_i) begin
                    if (mem_req_i && !if_starved) begin
                        gnt_d       = GNT_MEM;
                        bus_we_d    = mem_we_i;
                        bus_sel_d   = mem_sel_i;
                        bus_addr_d  = mem_addr_i;
                        bus_wdata_d = mem_wdata_i;
                        // Cannot overflow: MEM only wins at STARVE_MAX when IF is idle.
                        if (if_req_i) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end else begin
                        gnt_d       = GNT_IF;
                        bus_we_d    = 1'b0;
                        bus_sel_d   = SEL_WORD;
                        bus_addr_d  = if_addr_i;
                        bus_wdata_d = '0;
                        starve_d    = '0;
                    end
                    bus_ce_d = 1'b1;
                    wc_load  = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                wc_en = 1'b1;
                if (wc_last) begin
                    if (gnt_q == GNT_IF) begin
                        if_rdata_d = bus_rdata_i;
                        if_ack_d   = 1'b1;
                    end else begin
                        if (!bus_we_q) begin
                            mem_rdata_d = bus_rdata_i;
                        end
                        mem_ack_d = 1'b1;
                    end
                    bus_ce_d    = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = '0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    state_d     = DONE;
                end
            end
            // Requester still sees its req high here, so arbitration waits a cycle.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            bus_ce_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            bus_ce_q    <= bus_ce_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            starve_q    <= starve_d;
        end
    end

    assign bus_ce_o    = bus_ce_q;
    assign bus_we_o    = bus_we_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign mem_ack_o   = mem_ack_q;
    assign stall_if_o  = if_req_i & ~if_ack_q;
    assign stall_mem_o = mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_sopc_bus_arbiter.sv
// Directed bench for sopc_bus_arbiter: a MEM_LAT=2 instance for most scenarios
// and a MEM_LAT=1 instance for back-to-back fetch timing.
module tb_sopc_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata, if_rdata, mem_rdata;
    logic [3:0]  mem_sel, bus_sel;
    logic        if_ack, mem_ack, bus_ce, bus_we, stall_if, stall_mem;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    logic        b_if_req, b_mem_req, b_mem_we;
    logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata, b_if_rdata, b_mem_rdata;
    logic [3:0]  b_mem_sel, b_bus_sel;
    logic        b_if_ack, b_mem_ack, b_bus_ce, b_bus_we, b_stall_if, b_stall_mem;
    logic [31:0] b_bus_addr, b_bus_wdata, b_bus_rdata;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    // Memory model: word 0 holds a NOP, every other address returns addr + 0x1000_0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0013 : a + 32'h1000_0000;
    endfunction

    assign bus_rdata   = bus_ce   ? mem_word(bus_addr)   : 32'h0;
    assign b_bus_rdata = b_bus_ce ? mem_word(b_bus_addr) : 32'h0;

    sopc_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack),
        .bus_ce_o(bus_ce), .bus_we_o(bus_we), .bus_sel_o(bus_sel), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
        .stall_if_o(stall_if), .stall_mem_o(stall_mem)
    );

    sopc_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_rdata_o(b_if_rdata), .if_ack_o(b_if_ack),
        .mem_req_i(b_mem_req), .mem_we_i(b_mem_we), .mem_sel_i(b_mem_sel), .mem_addr_i(b_mem_addr),
        .mem_wdata_i(b_mem_wdata), .mem_rdata_o(b_mem_rdata), .mem_ack_o(b_mem_ack),
        .bus_ce_o(b_bus_ce), .bus_we_o(b_bus_we), .bus_sel_o(b_bus_sel), .bus_addr_o(b_bus_addr),
        .bus_wdata_o(b_bus_wdata), .bus_rdata_i(b_bus_rdata),
        .stall_if_o(b_stall_if), .stall_mem_o(b_stall_mem)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h0;
        tick();
        tick();
        total_cnt++;
        if ({bus_ce, bus_we, bus_sel, bus_addr, bus_wdata} !== 70'h0)
            $display("FAIL reset_bus: got ce=%b we=%b sel=%h addr=%h wd=%h, want all 0", bus_ce, bus_we, bus_sel, bus_addr, bus_wdata);
        else pass_cnt++;
        total_cnt++;
        if ({if_ack, mem_ack, if_rdata, mem_rdata} !== 66'h0)
            $display("FAIL reset_out: got acks=%b%b rdata=%h/%h, want 0", if_ack, mem_ack, if_rdata, mem_rdata);
        else pass_cnt++;
        total_cnt++;
        if (stall_if !== 1'b1) $display("FAIL reset_stall_if: got %b want 1", stall_if);
        else pass_cnt++;
        rst_n = 1'b1;                       // cycle 0: request seen in IDLE
        tick();
        total_cnt++;
        if ({bus_ce, bus_we, bus_sel, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h0})
            $display("FAIL reset_fetch_c1: got ce=%b we=%b sel=%h addr=%h, want 1 0 f 0", bus_ce, bus_we, bus_sel, bus_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus_ce, if_ack} !== 2'b10) $display("FAIL reset_fetch_c2: got ce=%b ack=%b want 1 0", bus_ce, if_ack);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({if_ack, bus_ce, stall_if} !== 3'b100)
            $display("FAIL reset_fetch_c3: got ack=%b ce=%b stall=%b want 1 0 0", if_ack, bus_ce, stall_if);
        else pass_cnt++;
        total_cnt++;
        if (if_rdata !== 32'h0000_0013) $display("FAIL reset_fetch_rdata: got %h want 00000013", if_rdata);
        else pass_cnt++;
        if_req = 1'b0;
        tick();
        $display("txn reset+fetch addr=00000000 rdata=%h", if_rdata);
    endtask

    task automatic test_load_store();
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h200; mem_wdata = 32'h0;
        tick();
        total_cnt++;
        if ({bus_ce, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h200})
            $display("FAIL load_c1: got ce=%b we=%b addr=%h want 1 0 200", bus_ce, bus_we, bus_addr);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if ({mem_ack, mem_rdata} !== {1'b1, 32'h1000_0200})
            $display("FAIL load_ack: got ack=%b rdata=%h want 1 10000200", mem_ack, mem_rdata);
        else pass_cnt++;
        mem_req = 1'b0;
        tick();
        $display("txn load addr=00000200 rdata=%h", mem_rdata);

        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 2; c++) begin
            tick();
            total_cnt++;
            if ({bus_ce, bus_we, bus_sel, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF})
                $display("FAIL store_c%0d: got ce=%b we=%b sel=%h addr=%h wd=%h", c, bus_ce, bus_we, bus_sel, bus_addr, bus_wdata);
            else pass_cnt++;
            total_cnt++;
            if (mem_ack !== 1'b0) $display("FAIL store_early_ack_c%0d: got %b want 0", c, mem_ack);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({mem_ack, bus_ce, bus_we, bus_sel} !== {1'b1, 1'b0, 1'b0, 4'h0})
            $display("FAIL store_ack: got ack=%b ce=%b we=%b sel=%h want 1 0 0 0", mem_ack, bus_ce, bus_we, bus_sel);
        else pass_cnt++;
        total_cnt++;
        if (mem_rdata !== 32'h1000_0200) $display("FAIL store_rdata_hold: got %h want 10000200", mem_rdata);
        else pass_cnt++;
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        $display("txn store addr=00000100 wdata=deadbeef mem_rdata=%h", mem_rdata);
    endtask

    task automatic test_arbitration();
        logic exp_gnt [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};   // 1 = MEM
        if_req = 1'b1; if_addr = 32'h40;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300;
        for (int i = 0; i < 6; i++) begin
            tick();
            total_cnt++;
            if (bus_addr !== (exp_gnt[i] ? 32'h300 : 32'h40))
                $display("FAIL arb_addr_%0d: got %h want %h", i, bus_addr, exp_gnt[i] ? 32'h300 : 32'h40);
            else pass_cnt++;
            tick();
            tick();
            total_cnt++;
            if ({mem_ack, if_ack} !== {exp_gnt[i], ~exp_gnt[i]})
                $display("FAIL arb_ack_%0d: got mem_ack=%b if_ack=%b want %b %b", i, mem_ack, if_ack, exp_gnt[i], ~exp_gnt[i]);
            else pass_cnt++;
            $display("txn arb %0d grant=%s if_ack=%b mem_ack=%b", i, exp_gnt[i] ? "MEM" : "IF", if_ack, mem_ack);
            if (i == 4) begin
                total_cnt++;
                if (if_rdata !== 32'h1000_0040) $display("FAIL arb_if_rdata: got %h want 10000040", if_rdata);
                else pass_cnt++;
            end
            if (i == 5) begin
                if_req = 1'b0; mem_req = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_access();
        if_req = 1'b1; if_addr = 32'h80;
        tick();
        tick();                             // second ACCESS cycle
        total_cnt++;
        if (bus_ce !== 1'b1) $display("FAIL rst_mid_pre: got ce=%b want 1", bus_ce);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus_ce, if_ack, if_rdata} !== 34'h0)
            $display("FAIL rst_mid_drop: got ce=%b ack=%b rdata=%h want 0", bus_ce, if_ack, if_rdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus_ce, if_ack} !== 2'b00) $display("FAIL rst_mid_hold: got ce=%b ack=%b want 0 0", bus_ce, if_ack);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if ({bus_ce, bus_addr} !== {1'b1, 32'h80}) $display("FAIL rst_mid_restart: got ce=%b addr=%h want 1 80", bus_ce, bus_addr);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if ({if_ack, if_rdata} !== {1'b1, 32'h1000_0080})
            $display("FAIL rst_mid_ack: got ack=%b rdata=%h want 1 10000080", if_ack, if_rdata);
        else pass_cnt++;
        if_req = 1'b0;
        tick();
        $display("txn reset-mid-access fetch addr=00000080 rdata=%h", if_rdata);
    endtask

    task automatic test_mem_drop();
        int acks = 0;
        int ces  = 0;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h400;
        tick();
        mem_req = 1'b0;
        tick();
        total_cnt++;
        if ({bus_ce, stall_mem} !== 2'b10) $display("FAIL drop_c2: got ce=%b stall=%b want 1 0", bus_ce, stall_mem);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({mem_ack, mem_rdata} !== {1'b1, 32'h1000_0400})
            $display("FAIL drop_ack: got ack=%b rdata=%h want 1 10000400", mem_ack, mem_rdata);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            tick();
            acks += int'(mem_ack) + int'(if_ack);
            ces  += int'(bus_ce);
        end
        total_cnt++;
        if (acks != 0 || ces != 0) $display("FAIL drop_idle: got %0d acks %0d ce-cycles, want 0 0", acks, ces);
        else pass_cnt++;
        $display("txn mem-drop load addr=00000400 rdata=%h", mem_rdata);
    endtask

    task automatic test_back_to_back_lat1();
        b_if_req = 1'b1; b_if_addr = 32'h0;
        tick();
        total_cnt++;
        if ({b_bus_ce, b_stall_if, b_if_ack} !== 3'b110) $display("FAIL b2b_c1: got ce=%b stall=%b ack=%b want 1 1 0", b_bus_ce, b_stall_if, b_if_ack);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({b_if_ack, b_stall_if, b_if_rdata} !== {1'b1, 1'b0, 32'h13})
            $display("FAIL b2b_ack0: got ack=%b stall=%b rdata=%h want 1 0 00000013", b_if_ack, b_stall_if, b_if_rdata);
        else pass_cnt++;
        $display("txn b2b fetch addr=00000000 rdata=%h", b_if_rdata);
        b_if_addr = 32'h4;
        tick();
        total_cnt++;
        if ({b_bus_ce, b_stall_if, b_if_ack} !== 3'b010) $display("FAIL b2b_idle: got ce=%b stall=%b ack=%b want 0 1 0", b_bus_ce, b_stall_if, b_if_ack);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({b_bus_ce, b_bus_addr, b_stall_if} !== {1'b1, 32'h4, 1'b1})
            $display("FAIL b2b_c4: got ce=%b addr=%h stall=%b want 1 4 1", b_bus_ce, b_bus_addr, b_stall_if);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({b_if_ack, b_stall_if, b_if_rdata} !== {1'b1, 1'b0, 32'h1000_0004})
            $display("FAIL b2b_ack1: got ack=%b stall=%b rdata=%h want 1 0 10000004", b_if_ack, b_stall_if, b_if_rdata);
        else pass_cnt++;
        $display("txn b2b fetch addr=00000004 rdata=%h", b_if_rdata);
        b_if_req = 1'b0;
        tick();
        total_cnt++;
        if ({b_if_ack, b_bus_ce} !== 2'b00) $display("FAIL b2b_end: got ack=%b ce=%b want 0 0", b_if_ack, b_bus_ce);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0;
        b_mem_req = 1'b0; b_mem_we = 1'b0; b_mem_sel = '0; b_mem_addr = '0; b_mem_wdata = '0;
        test_reset();
        test_load_store();
        test_arbitration();
        test_reset_mid_access();
        test_mem_drop();
        test_back_to_back_lat1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sopc_bus_arbiter.md
Name: sopc_bus_arbiter

Overview:
- Shares the SOPC's single-port instruction/data memory between the instruction-fetch port and the load/store (MEM) port of the RV32I core.
- Arbitrates between the two ports, sequences each access over a configurable number of wait states, and returns registered read data with a one-cycle ack.
- Drives per-port stall requests to the pipeline control logic.

Parameters:
- ADDR_W, 32, address width of both ports and the memory bus.
- DATA_W, 32, data width.
- MEM_LAT, 2, wait-state cycles that bus_ce is held per access; legal range 1..7.
- STARVE_MAX, 4, consecutive MEM grants allowed while if_req is pending before IF is forced to win.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; a level held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid when if_ack=1.
- if_ack  out  1  one-cycle completion pulse.
- mem_req  in  1  load/store request; a level held until mem_ack.
- mem_we  in  1  1 = store.
- mem_sel  in  4  byte enables.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; valid when mem_ack=1.
- mem_ack  out  1  one-cycle completion pulse.
- bus_ce  out  1  memory chip enable.
- bus_we  out  1  memory write enable.
- bus_sel  out  4  memory byte enables.
- bus_addr  out  ADDR_W  memory address.
- bus_wdata  out  DATA_W  memory write data.
- bus_rdata  in  DATA_W  memory read data.
- stall_if  out  1  stall request for the fetch stage.
- stall_mem  out  1  stall request for the memory stage.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE, wait counter=0, starve_cnt=0.
  - All bus_* outputs, both acks and both rdata outputs are 0.
  - Reset during an access drops bus_ce immediately; no ack is issued.
- FSM states:
  - IDLE: if any request is pending, latch the winner and its address, we, sel and wdata into the bus registers, then go to ACCESS.
  - ACCESS: bus_ce=1 for exactly MEM_LAT cycles, with the wait counter running 0..MEM_LAT-1.
    - On the last ACCESS cycle: capture bus_rdata into the winner's rdata register, drop bus_ce, go to DONE.
  - DONE: the winner's ack=1 for one cycle; go to IDLE unconditionally.
    - No arbitration happens in DONE, because the requester's req is still high that cycle.
- Registered bus outputs:
  - IF grant: bus_we=0, bus_sel=4'hF, bus_addr=if_addr.
  - MEM grant: bus_we=mem_we, bus_sel=mem_sel, bus_addr=mem_addr, bus_wdata=mem_wdata.
  - Outside ACCESS all bus_* outputs are 0.
- Latency and throughput:
  - req seen in IDLE at cycle 0 → bus_ce high for cycles 1..MEM_LAT → ack at cycle MEM_LAT+1.
  - Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Arbitration (evaluated in IDLE only):
  - Only one requester → it wins.
  - Both requesters → MEM wins, unless starve_cnt==STARVE_MAX, in which case IF wins.
  - starve_cnt increments on each MEM grant made while if_req=1 (saturating at STARVE_MAX); it clears on every IF grant.
- Stores: ack is issued as for reads; mem_rdata keeps its previous value.
- rdata outputs hold their last captured value until the next read completes on that port.
- Requester drops req during ACCESS: the access still completes and the ack is still issued.
- Addresses pass through unmodified; alignment checking belongs to the core.
- stall_if = if_req & ~if_ack; stall_mem = mem_req & ~mem_ack (both combinational).

Decomposition:
- Shared package sopc_bus_pkg holds:
  - the state encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - grant encodings: GNT_IF=1'b0, GNT_MEM=1'b1;
  - SEL_WORD=4'hF.
- One sub-module is natural: sopc_bus_waitcnt. It is a loadable down-counter with a last-cycle flag, reused by the peripheral bridge.

Test Plan:
- Reset with if_req=1 held, then release → bus_ce stays 0 during reset; after release, bus_ce=1 for cycles 1–2, if_ack=1 at cycle 3 with if_rdata=0x00000013 returned by the memory model.
- MEM store: mem_we=1, sel=4'b0011, addr=0x100, wdata=0xDEADBEEF → bus_we=1, bus_sel=4'b0011 for 2 cycles; mem_ack at cycle 3; mem_rdata unchanged.
- if_req and mem_req held continuously → grant order MEM,MEM,MEM,MEM,IF,MEM…; one ack every 4 cycles (MEM_LAT=2).
- rst pulsed low in the 2nd ACCESS cycle of an IF read → bus_ce=0 in the same cycle, no if_ack; access restarts from IDLE once rst returns high.
- MEM_LAT=1 with back-to-back IF reads at 0x0, 0x4 → acks 3 cycles apart; stall_if low only in the ack cycles.
- mem_req dropped in the middle of ACCESS → mem_ack still pulses exactly once; FSM returns to IDLE and stays there with bus_ce=0.
